// File: rtl/int_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package int_div_pkg;

  localparam int DEFAULT_NBITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Field positions inside a 2*n wide message: high half is dividend/quotient.
  function automatic int msg_hi_msb(input int n);
    return 2*n - 1;
  endfunction

  function automatic int msg_hi_lsb(input int n);
    return n;
  endfunction

  function automatic int msg_lo_msb(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/int_div_if.sv
// Request/response val/rdy streams of the divider, shared with the multiplier harness.
interface int_div_if
  import int_div_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
);

  logic               istream_val;
  logic               istream_rdy;
  logic [2*NBITS-1:0] istream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [2*NBITS-1:0] ostream_msg;

  modport master (
    output istream_val,
    input  istream_rdy,
    output istream_msg,
    input  ostream_val,
    output ostream_rdy,
    input  ostream_msg
  );

  modport slave (
    input  istream_val,
    output istream_rdy,
    input  istream_msg,
    output ostream_val,
    input  ostream_rdy,
    output ostream_msg
  );

endinterface

// File: rtl/int_div_dpath.sv
// Divider datapath: operand registers, one restoring shift/subtract step per cycle,
// and the step counter.
module int_div_dpath
  import int_div_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic             counter_done,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder
);

  localparam int CW = $clog2(NBITS) + 1;

  logic [NBITS-1:0] dvs_q;
  logic [NBITS-1:0] quo_q;
  // The partial remainder stays below the divisor, so its stored form needs
  // only NBITS bits; the extra bit exists only in the shifted/difference path.
  logic [NBITS-1:0] rem_q;
  logic [CW-1:0]    cnt_q;

  logic [NBITS:0]   rem_shift;
  logic [NBITS:0]   diff;
  logic [NBITS-1:0] quo_shift;
  logic [NBITS-1:0] rem_next;
  logic [NBITS-1:0] quo_next;

  always_comb begin
    rem_shift = {rem_q, quo_q[NBITS-1]};
    quo_shift = {quo_q[NBITS-2:0], 1'b0};
    diff      = rem_shift - {1'b0, dvs_q};
    rem_next  = rem_shift[NBITS-1:0];
    quo_next  = quo_shift;
    if (!diff[NBITS]) begin
      rem_next = diff[NBITS-1:0];
      quo_next = quo_shift | {{(NBITS-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      dvs_q <= divisor;
      quo_q <= dividend;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      quo_q <= quo_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign counter_done = (cnt_q == CW'(NBITS - 1));
  assign quotient     = quo_q;
  assign remainder    = rem_q;

endmodule

// File: rtl/int_div_iterative.sv
// Iterative unsigned divider: fixed NBITS-cycle restoring division behind val/rdy streams.
//
// state | meaning
// IDLE  | ready for a request; accepting loads the datapath
// CALC  | one quotient bit per cycle, exactly NBITS cycles
// DONE  | result valid and held until the sink takes it
module int_div_iterative
  import int_div_pkg::*;
#(
  parameter int NBITS = DEFAULT_NBITS
) (
  input  logic     clk,
  input  logic     reset,
  int_div_if.slave io
);

  localparam int HI_MSB = msg_hi_msb(NBITS);
  localparam int HI_LSB = msg_hi_lsb(NBITS);
  localparam int LO_MSB = msg_lo_msb(NBITS);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             counter_done;
  logic [NBITS-1:0] quotient;
  logic [NBITS-1:0] remainder;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (io.istream_val) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (counter_done) state_next = DONE;
      end
      DONE: begin
        if (io.ostream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  int_div_dpath #(
    .NBITS(NBITS)
  ) u_dpath (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .dividend     (io.istream_msg[HI_MSB:HI_LSB]),
    .divisor      (io.istream_msg[LO_MSB:0]),
    .counter_done (counter_done),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  assign io.istream_rdy = (state == IDLE);
  assign io.ostream_val = (state == DONE);
  assign io.ostream_msg = {quotient, remainder};

endmodule

// File: tb/tb_int_div_iterative.sv
// Directed bench for int_div_iterative with hand-computed quotient/remainder vectors.
module tb_int_div_iterative;
  import int_div_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic watch;
  logic seen_val;

  int_div_if #(.NBITS(32)) bus ();

  int_div_iterative #(.NBITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(bus.ostream_val) if (watch && bus.ostream_val) seen_val = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until ostream_val rises (bounded).
  task automatic wait_val(output int n);
    n = 0;
    while (!bus.ostream_val && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    bus.istream_msg = {a, b};
    bus.istream_val = 1'b1;
    n = 0;
    while (!bus.istream_rdy && n < 100) begin
      tick();
      n++;
    end
    check({tag, " in_rdy"}, 64'(bus.istream_rdy), 64'd1);
    tick();
    bus.istream_val = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int n;
    send(a, b, tag);
    wait_val(n);
    check({tag, " latency"}, 64'(n), 64'd32);
    check({tag, " msg"}, bus.ostream_msg, exp);
    bus.ostream_rdy = 1'b1;
    tick();
    bus.ostream_rdy = 1'b0;
    check({tag, " back_idle"}, {62'd0, bus.istream_rdy, bus.ostream_val}, 64'b10);
  endtask

  initial begin
    int n;
    int cyc;
    int acc;
    int nres;
    int acc_cyc[2];
    logic [63:0] res[2];
    logic fire_i;
    logic fire_o;

    total = 0;
    bad = 0;
    watch = 1'b0;
    seen_val = 1'b0;
    reset = 1'b1;
    bus.istream_val = 1'b0;
    bus.istream_msg = '0;
    bus.ostream_rdy = 1'b0;
    tick();
    tick();
    check("reset out_val", 64'(bus.ostream_val), 64'd0);
    check("reset out_msg", bus.ostream_msg, 64'd0);
    check("reset in_rdy", 64'(bus.istream_rdy), 64'd1);
    reset = 1'b0;
    tick();

    // 100/7: valid after 32 more edges, low one edge earlier
    send(32'd100, 32'd7, "d100_7");
    for (int i = 0; i < 31; i++) tick();
    check("d100_7 early_val", 64'(bus.ostream_val), 64'd0);
    tick();
    check("d100_7 val", 64'(bus.ostream_val), 64'd1);
    check("d100_7 msg", bus.ostream_msg, 64'h0000000E_00000002);
    bus.ostream_rdy = 1'b1;
    tick();
    bus.ostream_rdy = 1'b0;

    run_op(32'hFFFFFFFF, 32'd1, 64'hFFFFFFFF_00000000, "max_1");
    run_op(32'd5, 32'd0, 64'hFFFFFFFF_00000005, "d5_0");
    run_op(32'd0, 32'd0, 64'hFFFFFFFF_00000000, "d0_0");

    // 1000/33 held under backpressure, then a request presented on the transfer cycle
    send(32'd1000, 32'd33, "bp");
    wait_val(n);
    check("bp latency", 64'(n), 64'd32);
    for (int i = 0; i < 5; i++) begin
      check("bp hold_msg", bus.ostream_msg, 64'h0000001E_0000000A);
      check("bp hold_rdy", {62'd0, bus.istream_rdy, bus.ostream_val}, 64'b01);
      tick();
    end
    bus.ostream_rdy = 1'b1;
    bus.istream_val = 1'b1;
    bus.istream_msg = {32'd3, 32'd10};
    check("bp xfer", {62'd0, bus.ostream_val, bus.istream_rdy}, 64'b10);
    tick();
    bus.ostream_rdy = 1'b0;
    check("bp next_rdy", {62'd0, bus.istream_rdy, bus.ostream_val}, 64'b10);
    tick();
    bus.istream_val = 1'b0;
    check("d3_10 accepted", 64'(bus.istream_rdy), 64'd0);
    wait_val(n);
    check("d3_10 latency", 64'(n), 64'd32);
    check("d3_10 msg", bus.ostream_msg, 64'h00000000_00000003);
    bus.ostream_rdy = 1'b1;
    tick();

    // back-to-back with source always valid and sink always ready
    cyc = 0;
    acc = 0;
    nres = 0;
    bus.istream_val = 1'b1;
    bus.istream_msg = {32'h80000000, 32'd2};
    while (nres < 2 && cyc < 200) begin
      fire_i = bus.istream_val && bus.istream_rdy;
      fire_o = bus.ostream_val && bus.ostream_rdy;
      if (fire_o) begin
        res[nres] = bus.ostream_msg;
        nres++;
      end
      tick();
      cyc++;
      if (fire_i) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc == 1) bus.istream_msg = {32'h12345678, 32'h1000};
        else bus.istream_val = 1'b0;
      end
    end
    bus.ostream_rdy = 1'b0;
    check("b2b accepts", 64'(acc), 64'd2);
    check("b2b results", 64'(nres), 64'd2);
    if (acc == 2) check("b2b spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd34);
    if (nres == 2) begin
      check("b2b res0", res[0], 64'h40000000_00000000);
      check("b2b res1", res[1], 64'h00012345_00000678);
    end

    // reset during CALC cycle 10 of 50/5
    tick();
    watch = 1'b1;
    send(32'd50, 32'd5, "abort");
    for (int i = 0; i < 9; i++) tick();
    check("abort in_calc", 64'(bus.istream_rdy), 64'd0);
    reset = 1'b1;
    #1;
    check("abort async_idle", {62'd0, bus.istream_rdy, bus.ostream_val}, 64'b10);
    tick();
    tick();
    reset = 1'b0;
    bus.ostream_rdy = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    bus.ostream_rdy = 1'b0;
    watch = 1'b0;
    check("abort no_resp", 64'(seen_val), 64'd0);
    check("abort rdy", 64'(bus.istream_rdy), 64'd1);
    run_op(32'd9, 32'd4, 64'h00000002_00000001, "d9_4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
